// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM fill-then-readback self-test controller.
// The pattern generator is used both for write data and for expected read data.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    // Largest RAM read latency the checker pipeline can absorb.
    localparam int unsigned MAX_READ_LAT = 1;

    // pattern(k) = (2*k + seed) mod 2**dw, computed wide and then masked.
    function automatic logic [31:0] pattern(
        input logic [31:0] k,
        input logic [31:0] seed,
        input int unsigned dw
    );
        logic [63:0] sum;
        logic [63:0] mask;
        sum  = {31'b0, k, 1'b0} + {32'b0, seed};
        mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        return 32'(sum & mask);
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Expected-data pipeline and read comparator for the RAM self-test.
// Counts mismatches with saturation and captures details of the first one.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 8,
    parameter int unsigned CW       = AW + 1,
    parameter int unsigned READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    input  logic [DW-1:0] rdata,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got
);

    logic          cmp_valid;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_exp;
    logic          mismatch;

    if (READ_LAT == 0) begin : g_comb_read
        assign cmp_valid = in_valid;
        assign cmp_addr  = in_addr;
        assign cmp_exp   = in_exp;
    end else begin : g_reg_read
        // Expected value and address wait one cycle for registered RAM data.
        logic          pipe_valid;
        logic [AW-1:0] pipe_addr;
        logic [DW-1:0] pipe_exp;

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                pipe_valid <= 1'b0;
                pipe_addr  <= '0;
                pipe_exp   <= '0;
            end else begin
                pipe_valid <= in_valid;
                pipe_addr  <= in_addr;
                pipe_exp   <= in_exp;
            end
        end

        assign cmp_valid = pipe_valid;
        assign cmp_addr  = pipe_addr;
        assign cmp_exp   = pipe_exp;
    end

    assign mismatch = cmp_valid && (rdata != cmp_exp);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            // A saturated count never returns to zero, so this is first-only.
            if (err_count == '0) begin
                fail_addr <= cmp_addr;
                fail_exp  <= cmp_exp;
                fail_got  <= rdata;
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// Fill-then-readback self-test initiator for a single-port RAM.
// Owns the sequencing FSM and address counter; comparison lives in ram_bist_checker.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 8,
    parameter int unsigned SEED     = 0,
    parameter int unsigned READ_LAT = 0,
    parameter int unsigned CW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_select,
    input  logic [DW-1:0] mem_rdata
);

    if (READ_LAT > MAX_READ_LAT) begin : g_read_lat_check
        $error("ram_bist_ctrl: READ_LAT must be 0 or 1");
    end

    localparam logic [AW-1:0] LAST_ADDR = '1;

    bist_state_t   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] addr_inc;
    logic          accept;
    logic          last_beat;

    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          mem_write_d;
    logic          mem_select_d;

    logic          chk_valid;
    logic [DW-1:0] chk_exp;

    assign addr_inc  = addr_q + 1'b1;
    assign last_beat = (addr_q == LAST_ADDR);
    assign chk_exp   = DW'(pattern(32'(addr_q), 32'(SEED), DW));

    // Bus values are computed for the next cycle so every mem_* output is a flop.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        accept       = 1'b0;
        chk_valid    = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_write_d  = 1'b0;
        mem_select_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept       = 1'b1;
                    state_d      = ST_FILL;
                    addr_d       = '0;
                    mem_wdata_d  = DW'(pattern(32'd0, 32'(SEED), DW));
                    mem_write_d  = 1'b1;
                    mem_select_d = 1'b1;
                end
            end
            ST_FILL: begin
                mem_select_d = 1'b1;
                if (last_beat) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end else begin
                    addr_d      = addr_inc;
                    mem_addr_d  = addr_inc;
                    mem_wdata_d = DW'(pattern(32'(addr_inc), 32'(SEED), DW));
                    mem_write_d = 1'b1;
                end
            end
            ST_READ: begin
                chk_valid = 1'b1;
                if (last_beat) begin
                    state_d = (READ_LAT != 0) ? ST_DRAIN : ST_DONE;
                    addr_d  = '0;
                end else begin
                    addr_d       = addr_inc;
                    mem_addr_d   = addr_inc;
                    mem_select_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_select <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_write  <= mem_write_d;
            mem_select <= mem_select_d;
        end
    end

    assign busy = (state_q == ST_FILL) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);
    assign pass = done && (err_count == '0);

    ram_bist_checker #(
        .AW      (AW),
        .DW      (DW),
        .CW      (CW),
        .READ_LAT(READ_LAT)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .in_valid (chk_valid),
        .in_addr  (addr_q),
        .in_exp   (chk_exp),
        .rdata    (mem_rdata),
        .err_count(err_count),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: three configurations, behavioural RAM models
// with selectable faults, a bus scoreboard and a table of end-of-test expectations.
module tb_ram_bist_ctrl;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [3];
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        pass_v  [3];
    logic [10:0] err_v   [3];
    logic [9:0]  faddr_v [3];
    logic [7:0]  fexp_v  [3];
    logic [7:0]  fgot_v  [3];
    logic [9:0]  addr_v  [3];
    logic [7:0]  wdata_v [3];
    logic        write_v [3];
    logic        sel_v   [3];
    logic [7:0]  rdata0, rdata1, rdata2;
    logic [3:0]  err2;
    int          fault_v [3];
    logic [7:0]  mem [3][DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    ram_bist_ctrl #(.AW(10), .DW(8), .SEED(0), .READ_LAT(0), .CW(11)) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_v[0]), .fail_addr(faddr_v[0]), .fail_exp(fexp_v[0]),
        .fail_got(fgot_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]),
        .mem_write(write_v[0]), .mem_select(sel_v[0]), .mem_rdata(rdata0));

    ram_bist_ctrl #(.AW(10), .DW(8), .SEED(0), .READ_LAT(1), .CW(11)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_v[1]), .fail_addr(faddr_v[1]), .fail_exp(fexp_v[1]),
        .fail_got(fgot_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]),
        .mem_write(write_v[1]), .mem_select(sel_v[1]), .mem_rdata(rdata1));

    ram_bist_ctrl #(.AW(10), .DW(8), .SEED(0), .READ_LAT(0), .CW(4)) dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err2), .fail_addr(faddr_v[2]), .fail_exp(fexp_v[2]),
        .fail_got(fgot_v[2]), .mem_addr(addr_v[2]), .mem_wdata(wdata_v[2]),
        .mem_write(write_v[2]), .mem_select(sel_v[2]), .mem_rdata(rdata2));

    assign err_v[2] = {7'b0, err2};

    // Fault modes: 0 good, 1 bit0 forced high at 37, 2 inverted, 3 zero at 900.
    function automatic logic [7:0] ram_out(input int mode, input logic [9:0] a, input logic [7:0] d);
        case (mode)
            1:       return (a == 10'd37) ? (d | 8'h01) : d;
            2:       return ~d;
            3:       return (a == 10'd900) ? 8'h00 : d;
            default: return d;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int k);
        int v;
        v = (2 * k) % 256;
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sel_v[i] && write_v[i]) mem[i][addr_v[i]] <= wdata_v[i];
        end
    end

    assign rdata0 = ram_out(fault_v[0], addr_v[0], mem[0][addr_v[0]]);
    assign rdata2 = ram_out(fault_v[2], addr_v[2], mem[2][addr_v[2]]);

    always @(posedge clk) begin
        if (sel_v[1] && !write_v[1]) rdata1 <= ram_out(fault_v[1], addr_v[1], mem[1][addr_v[1]]);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- bus scoreboard ----------------
    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       write;
    } beat_t;

    beat_t sbq[$];
    int    bus_err;
    string bus_msg;

    task automatic sb_reset();
        sbq.delete();
        bus_err = 0;
        bus_msg = "";
    endtask

    task automatic push_full_run();
        beat_t b;
        for (int k = 0; k < DEPTH; k++) begin
            b.addr = 10'(k); b.wdata = pat(k); b.write = 1'b1;
            sbq.push_back(b);
        end
        for (int k = 0; k < DEPTH; k++) begin
            b.addr = 10'(k); b.wdata = 8'h00; b.write = 1'b0;
            sbq.push_back(b);
        end
    endtask

    task automatic sb_step(input int d);
        beat_t b;
        if (sel_v[d]) begin
            if (sbq.size() == 0) begin
                if (bus_err == 0) bus_msg = $sformatf("unexpected beat addr %0d", addr_v[d]);
                bus_err++;
            end else begin
                b = sbq.pop_front();
                if (addr_v[d] !== b.addr || wdata_v[d] !== b.wdata || write_v[d] !== b.write) begin
                    if (bus_err == 0)
                        bus_msg = $sformatf("addr/wdata/write %0d/%0d/%0d vs %0d/%0d/%0d",
                                            addr_v[d], wdata_v[d], write_v[d], b.addr, b.wdata, b.write);
                    bus_err++;
                end
            end
        end else if (write_v[d]) begin
            if (bus_err == 0) bus_msg = "write without select";
            bus_err++;
        end
    endtask

    task automatic check_bus(input string name);
        if (bus_err != 0) $display("  first bus difference in %s: %s", name, bus_msg);
        check({name, ".bus_errors"}, 64'(bus_err), 64'd0);
        check({name, ".beats_left"}, 64'(sbq.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    dut;
        int    fault;
        bit    repulse;
        int    done_cyc;
        bit    pass;
        int    err;
        int    faddr;
        int    fexp;
        int    fgot;
    } vec_t;

    function automatic vec_t mk(input string name, input int dut, input int fault, input bit repulse,
                                input int done_cyc, input bit pass, input int err,
                                input int faddr, input int fexp, input int fgot);
        vec_t v;
        v.name = name; v.dut = dut; v.fault = fault; v.repulse = repulse;
        v.done_cyc = done_cyc; v.pass = pass; v.err = err;
        v.faddr = faddr; v.fexp = fexp; v.fgot = fgot;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int d;
        int cyc;
        d = v.dut;
        fault_v[d] = v.fault;
        sb_reset();
        push_full_run();
        @(negedge clk) start_v[d] = 1'b1;
        @(negedge clk) start_v[d] = 1'b0;
        cyc = 1;
        check({v.name, ".busy_c1"}, 64'(busy_v[d]), 64'd1);
        check({v.name, ".done_c1"}, 64'(done_v[d]), 64'd0);
        while (1) begin
            sb_step(d);
            if (cyc == 129)
                check({v.name, ".c129"}, {54'd0, addr_v[d], wdata_v[d]}, {54'd0, 10'd128, 8'd0});
            if (cyc == 1024)
                check({v.name, ".c1024"}, {54'd0, addr_v[d], wdata_v[d]}, {54'd0, 10'd1023, 8'd254});
            if (done_v[d] === 1'b1 || cyc >= 2300) break;
            start_v[d] = (v.repulse && cyc == DEPTH + 1 + 300);
            @(negedge clk);
            cyc++;
        end
        start_v[d] = 1'b0;
        check({v.name, ".done_cycle"}, 64'(cyc), 64'(v.done_cyc));
        check({v.name, ".busy_done"}, 64'(busy_v[d]), 64'd0);
        check({v.name, ".pass"}, 64'(pass_v[d]), 64'(v.pass));
        check({v.name, ".err_count"}, 64'(err_v[d]), 64'(v.err));
        check({v.name, ".fail_addr"}, 64'(faddr_v[d]), 64'(v.faddr));
        check({v.name, ".fail_exp"}, 64'(fexp_v[d]), 64'(v.fexp));
        check({v.name, ".fail_got"}, 64'(fgot_v[d]), 64'(v.fgot));
        check_bus(v.name);
    endtask

    function automatic logic [63:0] all_outputs(input int d);
        return {4'd0, busy_v[d], done_v[d], pass_v[d], err_v[d], faddr_v[d], fexp_v[d],
                fgot_v[d], addr_v[d], wdata_v[d], write_v[d], sel_v[d]};
    endfunction

    vec_t vecs[6];

    initial begin
        int cyc;

        vecs[0] = mk("good_lat0",  0, 0, 1'b0, 2049, 1'b1, 0,    0,   0,  0);
        vecs[1] = mk("bit0_at37",  0, 1, 1'b0, 2049, 1'b0, 1,    37,  74, 75);
        vecs[2] = mk("lat1_900",   1, 3, 1'b0, 2050, 1'b0, 1,    900, 8,  0);
        vecs[3] = mk("repulse",    0, 0, 1'b1, 2049, 1'b1, 0,    0,   0,  0);
        vecs[4] = mk("invert",     0, 2, 1'b0, 2049, 1'b0, 1024, 0,   0,  255);
        vecs[5] = mk("invert_cw4", 2, 2, 1'b0, 2049, 1'b0, 15,   0,   0,  255);

        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; fault_v[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("reset_outputs%0d", i), all_outputs(i), 64'd0);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in FILL while addr 500 is on the bus.
        fault_v[0] = 0;
        sb_reset();
        push_full_run();
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        cyc = 1;
        while (cyc < 501) begin
            sb_step(0);
            @(negedge clk);
            cyc++;
        end
        sb_step(0);
        check("rst_mid.addr500", {53'd0, write_v[0], addr_v[0]}, {53'd0, 1'b1, 10'd500});
        rst_v[0] = 1'b1;
        @(negedge clk) rst_v[0] = 1'b0;
        check("rst_mid.outputs", all_outputs(0), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_mid.idle", {62'd0, busy_v[0], write_v[0]}, 64'd0);
        run_vec(mk("after_rst", 0, 0, 1'b0, 2049, 1'b1, 0, 0, 0, 0));

        // start held high from DONE restarts, further start while busy is ignored.
        sb_reset();
        for (int k = 0; k < 3; k++) sbq.push_back('{addr: 10'(k), wdata: pat(k), write: 1'b1});
        start_v[0] = 1'b1;
        @(negedge clk);
        sb_step(0);
        check("restart.busy_done", {62'd0, busy_v[0], done_v[0]}, {62'd0, 1'b1, 1'b0});
        @(negedge clk) sb_step(0);
        @(negedge clk) sb_step(0);
        check("restart.addr2", 64'(addr_v[0]), 64'd2);
        start_v[0] = 1'b0;
        rst_v[0] = 1'b1;
        @(negedge clk) rst_v[0] = 1'b0;
        check_bus("restart");
        check("restart.busy_after_rst", 64'(busy_v[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
